// File: rtl/pipe_stage_hs_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_hs_if
//   Valid/ready handshake bundle used on both sides of pipe_stage_hs.
//
//   Parameters:
//     DATA_W  payload width in bits
//
//   Signals:
//     valid  producer has a payload this cycle
//     ready  consumer can take the payload this cycle
//     data   payload
//
//   Modports:
//     master  producer side (drives valid/data, observes ready)
//     slave   consumer side (observes valid/data, drives ready)
// ---------------------------------------------------------------------------
interface pipe_stage_hs_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// pipe_stage_hs
//   Valid/ready pipeline register for inter-stage boundaries (IF/ID, ID/EX,
//   EX/MEM, MEM/WB). A main register drives the output and a skid register
//   absorbs the one extra beat that can arrive while downstream stalls, so
//   in_ready is a plain flop and back-pressure never chains combinationally
//   from one stage to the next. Flush drops everything held plus any
//   same-cycle input and leaves a bubble behind.
//
//   Parameters:
//     DATA_W      payload width in bits (>= 1)
//     RESET_DATA  value on out data whenever out valid is low (NOP encoding)
//
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous active-high reset (priority over flush)
//     flush      synchronous discard of held entries and same-cycle input
//     in_if      upstream handshake (slave): valid/data in, ready out (registered)
//     out_if     downstream handshake (master): valid/data out (registered), ready in
//     occupancy  number of entries held: 0, 1 or 2 (registered)
//
//   Optional build macro PIPE_STAGE_STATS_EN adds:
//     stall_cnt  cycles with out valid high and out ready low (wraps, rst only)
//     xfer_cnt   output transfers (wraps, rst only)
// ---------------------------------------------------------------------------
module pipe_stage_hs #(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    pipe_stage_hs_if.slave     in_if,
    pipe_stage_hs_if.master    out_if,
`ifdef PIPE_STAGE_STATS_EN
    output logic [31:0]        stall_cnt,
    output logic [31:0]        xfer_cnt,
`endif
    output logic [1:0]         occupancy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic [1:0]        occ_q;

    logic in_xfer;
    logic out_xfer;

    // in_ready_q is already low in FULL, so in_xfer can never fire there.
    assign in_xfer  = in_if.valid & in_ready_q;
    assign out_xfer = out_valid_q & out_if.ready;

    // All outputs are flops; flags are updated alongside the state so they
    // never need decoding from state_q.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q     <= S_EMPTY;
            main_q      <= RESET_DATA;
            skid_q      <= RESET_DATA;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_xfer) begin
                        state_q     <= S_ONE;
                        main_q      <= in_if.data;
                        out_valid_q <= 1'b1;
                        occ_q       <= 2'd1;
                    end
                end
                S_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        // Downstream stalled: park the new beat in the skid.
                        state_q    <= S_FULL;
                        skid_q     <= in_if.data;
                        in_ready_q <= 1'b0;
                        occ_q      <= 2'd2;
                    end else if (in_xfer && out_xfer) begin
                        main_q <= in_if.data;
                    end else if (out_xfer) begin
                        state_q     <= S_EMPTY;
                        main_q      <= RESET_DATA;
                        out_valid_q <= 1'b0;
                        occ_q       <= 2'd0;
                    end
                end
                S_FULL: begin
                    if (out_xfer) begin
                        state_q    <= S_ONE;
                        main_q     <= skid_q;
                        skid_q     <= RESET_DATA;
                        in_ready_q <= 1'b1;
                        occ_q      <= 2'd1;
                    end
                end
                default: begin
                    state_q     <= S_EMPTY;
                    main_q      <= RESET_DATA;
                    skid_q      <= RESET_DATA;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    occ_q       <= 2'd0;
                end
            endcase
        end
    end

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = main_q;
    assign occupancy    = occ_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] xfer_cnt_q;
    logic [31:0] xfer_cnt_d;

    // Counters observe the raw handshake and ignore flush on purpose: they
    // measure link activity, not surviving payloads.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (out_valid_q && !out_if.ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (out_xfer) begin
            xfer_cnt_d = xfer_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            xfer_cnt_q  <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign xfer_cnt  = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_hs
//   Self-checking bench for pipe_stage_hs (DATA_W=96). The reference model is
//   a bounded FIFO of depth 2 held in a queue; expected outputs are the head
//   of that queue (or zero when empty) and its size.
// ---------------------------------------------------------------------------
module tb_pipe_stage_hs;
    localparam int DW = 96;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] xfer_cnt;
`endif

    pipe_stage_hs_if #(.DATA_W(DW)) in_if ();
    pipe_stage_hs_if #(.DATA_W(DW)) out_if ();

    pipe_stage_hs #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_if     (in_if),
        .out_if    (out_if),
`ifdef PIPE_STAGE_STATS_EN
        .stall_cnt (stall_cnt),
        .xfer_cnt  (xfer_cnt),
`endif
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit verbose = 1'b1;
    int model_xfers = 0;

    logic [DW-1:0] mq[$];

    function automatic logic exp_valid();
        return mq.size() > 0;
    endfunction

    function automatic logic [DW-1:0] exp_data();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    function automatic logic [1:0] exp_occ();
        return 2'(mq.size());
    endfunction

    function automatic logic exp_ready();
        return mq.size() < 2;
    endfunction

    // Advance one clock and update the reference FIFO from the inputs
    // presented before the edge. Inputs may be changed right after return.
    task automatic tick();
        bit            do_in;
        bit            do_out;
        logic [DW-1:0] d;
        logic [DW-1:0] head;
        do_in  = in_if.valid && (mq.size() < 2);
        do_out = (mq.size() > 0) && out_if.ready;
        d      = in_if.data;
        head   = exp_data();
        @(posedge clk);
        #1;
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (do_out) begin
                void'(mq.pop_front());
                model_xfers++;
                if (verbose) $display("  out xfer data=%h", head);
            end
            if (do_in) begin
                mq.push_back(d);
                if (verbose) $display("  in  xfer data=%h", d);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        in_if.valid = 1'b1; in_if.data = 96'hDEAD; out_if.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (out_if.valid !== 1'b0) begin
                bad++; $display("FAIL reset_valid cyc=%0d got=%b want=0", i, out_if.valid);
            end
            total++;
            if (out_if.data !== '0) begin
                bad++; $display("FAIL reset_data cyc=%0d got=%h want=0", i, out_if.data);
            end
        end
        total++;
        if (in_if.ready !== 1'b1 || occupancy !== 2'd0) begin
            bad++; $display("FAIL reset_ready_occ got ready=%b occ=%0d want ready=1 occ=0",
                            in_if.ready, occupancy);
        end
        rst = 1'b0; in_if.valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [DW-1:0] vals[3];
        vals[0] = 96'h11; vals[1] = 96'h22; vals[2] = 96'h33;
        out_if.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_if.valid = 1'b1; in_if.data = vals[i];
            tick();
            total++;
            if (out_if.valid !== 1'b1 || out_if.data !== vals[i]) begin
                bad++; $display("FAIL stream_%0d got v=%b d=%h want v=1 d=%h",
                                i, out_if.valid, out_if.data, vals[i]);
            end
        end
        in_if.valid = 1'b0;
        tick();
        total++;
        if (out_if.valid !== 1'b0 || out_if.data !== '0 || occupancy !== 2'd0) begin
            bad++; $display("FAIL stream_end got v=%b d=%h occ=%0d want v=0 d=0 occ=0",
                            out_if.valid, out_if.data, occupancy);
        end
    endtask

    task automatic test_skid();
        out_if.ready = 1'b0;
        in_if.valid = 1'b1; in_if.data = 96'hA1;
        tick();
        total++;
        if (occupancy !== 2'd1 || in_if.ready !== 1'b1) begin
            bad++; $display("FAIL skid_occ1 got occ=%0d rdy=%b want occ=1 rdy=1", occupancy, in_if.ready);
        end
        in_if.data = 96'hA2;
        tick();
        total++;
        if (occupancy !== 2'd2 || in_if.ready !== 1'b0) begin
            bad++; $display("FAIL skid_occ2 got occ=%0d rdy=%b want occ=2 rdy=0", occupancy, in_if.ready);
        end
        in_if.data = 96'hA3;
        tick();
        total++;
        if (occupancy !== 2'd2 || out_if.data !== 96'hA1 || out_if.valid !== 1'b1) begin
            bad++; $display("FAIL skid_hold got occ=%0d d=%h want occ=2 d=a1", occupancy, out_if.data);
        end
        out_if.ready = 1'b1;
        tick();
        total++;
        if (out_if.data !== 96'hA2 || in_if.ready !== 1'b1 || occupancy !== 2'd1) begin
            bad++; $display("FAIL skid_drain1 got d=%h rdy=%b occ=%0d want d=a2 rdy=1 occ=1",
                            out_if.data, in_if.ready, occupancy);
        end
        tick();
        total++;
        if (out_if.data !== 96'hA3 || occupancy !== 2'd1) begin
            bad++; $display("FAIL skid_drain2 got d=%h occ=%0d want d=a3 occ=1", out_if.data, occupancy);
        end
        in_if.valid = 1'b0;
        tick();
        total++;
        if (out_if.valid !== 1'b0 || occupancy !== 2'd0) begin
            bad++; $display("FAIL skid_drain3 got v=%b occ=%0d want v=0 occ=0", out_if.valid, occupancy);
        end
    endtask

    task automatic test_flush_full();
        out_if.ready = 1'b0;
        in_if.valid = 1'b1; in_if.data = 96'hB1;
        tick();
        in_if.data = 96'hB2;
        tick();
        total++;
        if (occupancy !== 2'd2) begin
            bad++; $display("FAIL flush_pre got occ=%0d want 2", occupancy);
        end
        in_if.data = 96'hB3; flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (out_if.valid !== 1'b0 || out_if.data !== '0 || occupancy !== 2'd0 || in_if.ready !== 1'b1) begin
            bad++; $display("FAIL flush_full got v=%b d=%h occ=%0d rdy=%b want v=0 d=0 occ=0 rdy=1",
                            out_if.valid, out_if.data, occupancy, in_if.ready);
        end
        in_if.valid = 1'b0; out_if.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_if.valid !== 1'b0) begin
                bad++; $display("FAIL flush_no_b3 cyc=%0d got v=%b d=%h want v=0", i, out_if.valid, out_if.data);
            end
        end
    endtask

    task automatic test_simultaneous();
`ifdef PIPE_STAGE_STATS_EN
        logic [31:0] x0;
`endif
        out_if.ready = 1'b0;
        in_if.valid = 1'b1; in_if.data = 96'hC1;
        tick();
`ifdef PIPE_STAGE_STATS_EN
        x0 = xfer_cnt;
`endif
        in_if.data = 96'hC2; out_if.ready = 1'b1;
        tick();
        in_if.valid = 1'b0; out_if.ready = 1'b0;
        total++;
        if (out_if.data !== 96'hC2 || out_if.valid !== 1'b1 || occupancy !== 2'd1) begin
            bad++; $display("FAIL simul got d=%h v=%b occ=%0d want d=c2 v=1 occ=1",
                            out_if.data, out_if.valid, occupancy);
        end
`ifdef PIPE_STAGE_STATS_EN
        total++;
        if (xfer_cnt !== x0 + 32'd1) begin
            bad++; $display("FAIL simul_xfer got=%0d want=%0d", xfer_cnt, x0 + 32'd1);
        end
`endif
        out_if.ready = 1'b1;
        tick();
        out_if.ready = 1'b0;
        total++;
        if (out_if.valid !== 1'b0) begin
            bad++; $display("FAIL simul_drain got v=%b want 0", out_if.valid);
        end
    endtask

    task automatic test_soak();
        int            n_out = 0;
        int            n_flush = 0;
        logic          pv;
        logic [DW-1:0] pd;
        verbose = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            in_if.valid  = ($urandom_range(0, 99) < 60);
            in_if.data   = {$urandom(), $urandom(), $urandom()};
            out_if.ready = ($urandom_range(0, 99) < 55);
            flush        = ($urandom_range(0, 99) == 0);
            if (flush) n_flush++;
            pv = out_if.valid; pd = out_if.data;
            if (exp_valid() && out_if.ready) n_out++;
            tick();
            total++;
            if (out_if.valid !== exp_valid() || out_if.data !== exp_data()) begin
                bad++; $display("FAIL soak_out cyc=%0d got v=%b d=%h want v=%b d=%h",
                                c, out_if.valid, out_if.data, exp_valid(), exp_data());
            end
            total++;
            if (in_if.ready !== exp_ready() || occupancy !== exp_occ()) begin
                bad++; $display("FAIL soak_ctl cyc=%0d got rdy=%b occ=%0d want rdy=%b occ=%0d",
                                c, in_if.ready, occupancy, exp_ready(), exp_occ());
            end
            total++;
            if (!out_if.valid && out_if.data !== '0) begin
                bad++; $display("FAIL soak_bubble cyc=%0d got d=%h want 0", c, out_if.data);
            end
        end
        flush = 1'b0; in_if.valid = 1'b0; out_if.ready = 1'b0;
        verbose = 1'b1;
        $display("soak: out transfers=%0d flushes=%0d", n_out, n_flush);
    endtask

`ifdef PIPE_STAGE_STATS_EN
    task automatic test_stats();
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if (stall_cnt !== 32'd0 || xfer_cnt !== 32'd0) begin
            bad++; $display("FAIL stats_rst0 got s=%0d x=%0d want 0 0", stall_cnt, xfer_cnt);
        end
        out_if.ready = 1'b0;
        in_if.valid = 1'b1; in_if.data = 96'hD1;
        tick();
        in_if.valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        in_if.valid = 1'b1; in_if.data = 96'hD2; out_if.ready = 1'b1;
        tick();
        in_if.data = 96'hD3;
        tick();
        in_if.valid = 1'b0;
        tick();
        out_if.ready = 1'b0;
        total++;
        if (stall_cnt !== 32'd5 || xfer_cnt !== 32'd3) begin
            bad++; $display("FAIL stats_count got s=%0d x=%0d want 5 3", stall_cnt, xfer_cnt);
        end
        flush = 1'b1; tick(); flush = 1'b0;
        total++;
        if (stall_cnt !== 32'd5 || xfer_cnt !== 32'd3) begin
            bad++; $display("FAIL stats_flush got s=%0d x=%0d want 5 3", stall_cnt, xfer_cnt);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if (stall_cnt !== 32'd0 || xfer_cnt !== 32'd0) begin
            bad++; $display("FAIL stats_rst got s=%0d x=%0d want 0 0", stall_cnt, xfer_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; flush = 1'b0;
        in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b0;
        test_reset();
        test_stream();
        test_skid();
        test_flush_full();
        test_simultaneous();
        test_soak();
`ifdef PIPE_STAGE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
